// File: rtl/booth_pkg.sv
// Shared definitions for the Booth MAC accumulator: FSM states, defaults, accumulator sizing.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam int DEF_BITS  = 8;
  localparam int DEF_TERMS = 4;

  // Wide enough that TERMS full-scale products can never overflow.
  function automatic int acc_width(input int bits, input int terms);
    return 2 * bits + $clog2(terms);
  endfunction

endpackage

// File: rtl/booth_mac_sat.sv
// Combinational clamp of the wide sum into the signed 2*BITS range, with a clip flag.
module booth_mac_sat #(
  parameter int BITS  = 8,
  parameter int ACC_W = 18
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [ACC_W-1:0] clamped,
  output logic                    clip
);

  localparam int PW = 2 * BITS;
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-PW+1){1'b0}}, {(PW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-PW+1){1'b1}}, {(PW-1){1'b0}}};

  always_comb begin
    clamped = sum;
    clip    = 1'b0;
    if (sum > MAXV) begin
      clamped = MAXV;
      clip    = 1'b1;
    end else if (sum < MINV) begin
      clamped = MINV;
      clip    = 1'b1;
    end
  end

endmodule

// File: rtl/booth_mac_acc.sv
// Accumulates TERMS signed products from the Booth multiplier into one widened sum.
// Optional output clamp and sat flag enabled by defining BOOTH_MAC_SAT_EN.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter  int BITS  = DEF_BITS,
  parameter  int TERMS = DEF_TERMS,
  localparam int ACC_W = acc_width(BITS, TERMS),
  localparam int CNT_W = $clog2(TERMS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    p_valid,
  output logic                    p_ready,
  input  logic signed [2*BITS-1:0] p_data,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    busy,
  output logic [CNT_W-1:0]        term_cnt
`ifdef BOOTH_MAC_SAT_EN
  ,
  output logic                    sat
`endif
);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    last;

  assign last = (cnt == CNT_W'(TERMS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ACCUM: begin
          // A restart wins over a same-cycle product, which is dropped.
          if (start) begin
            acc <= '0;
            cnt <= '0;
          end else if (p_valid) begin
            acc <= acc + ACC_W'(p_data);
            cnt <= cnt + 1'b1;
            if (last) state <= DONE;
          end
        end
        DONE: begin
          if (acc_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p_ready   = (state == ACCUM);
  assign acc_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign term_cnt  = cnt;

`ifdef BOOTH_MAC_SAT_EN
  logic signed [ACC_W-1:0] clamped;
  logic                    clip;

  booth_mac_sat #(.BITS(BITS), .ACC_W(ACC_W)) u_sat (
    .sum     (acc),
    .clamped (clamped),
    .clip    (clip)
  );

  // Only the presented result is clamped; the running sum stays full width.
  assign acc_out = acc_valid ? clamped : acc;
  assign sat     = acc_valid & clip;
`else
  assign acc_out = acc;
`endif

endmodule

// File: doc/booth_mac_acc.md
Name: booth_mac_acc

Overview:
- Downstream consumer of the combinational signed Booth multiplier.
- Takes a stream of signed 2*BITS-bit products and accumulates exactly TERMS of them into a widened signed sum, for example one dot-product lane.
- Sequenced by a small FSM with valid/ready handshakes on both sides.
- Output is held stable until the downstream stage accepts it.

Parameters:
- BITS, 8: operand width of the upstream multiplier; product width is 2*BITS.
- TERMS, 4: number of products summed per result; must be >= 1.
- ACC_W, 2*BITS+$clog2(TERMS) (localparam, not overridable): accumulator width, sized so the sum of TERMS products can never overflow.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a new accumulation
- p_valid  in  1  product on p_data is valid
- p_ready  out  1  block can accept a product this cycle
- p_data  in  2*BITS  signed product from the multiplier
- acc_valid  out  1  result on acc_out is valid
- acc_ready  in  1  downstream accepts the result
- acc_out  out  ACC_W  signed accumulated sum
- busy  out  1  high in ACCUM or DONE
- term_cnt  out  $clog2(TERMS+1)  products accepted so far in the current run

Interface decision: one clock, clk. Reset rst is synchronous and active-high.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, acc_out=0, term_cnt=0, acc_valid=0, p_ready=0, busy=0. Reset takes priority over every other input, including mid-ACCUM and mid-DONE; a partial sum is discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - p_ready=0, acc_valid=0.
  - start=1 -> ACCUM next cycle, with acc_out cleared to 0 and term_cnt cleared to 0.
  - p_valid is ignored.
- ACCUM:
  - p_ready=1.
  - Transfer occurs when p_valid && p_ready.
  - On transfer: acc_out <= acc_out + sign_extend(p_data, ACC_W); term_cnt <= term_cnt+1.
  - When the transfer is the TERMS-th: go to DONE next cycle.
  - A cycle with p_valid=0 is a stall; no state change.
- DONE:
  - p_ready=0, acc_valid=1, acc_out held stable.
  - acc_valid && acc_ready -> IDLE next cycle.
  - acc_out keeps its last value in IDLE; it is only cleared by a start or by rst.
- start while in ACCUM: restart. Clear acc_out and term_cnt, stay in ACCUM. A product presented in the same cycle is discarded, not accumulated.
- start while in DONE: ignored. The result must be consumed first.
- Latency:
  - start at edge t -> p_ready=1 from cycle t+1.
  - Last product accepted at edge t -> acc_valid=1 from cycle t+1.
  - Minimum full run is TERMS+2 cycles, back-to-back, with acc_ready tied high.
- Arithmetic:
  - Two's complement throughout.
  - Sign extension of p_data is mandatory.
  - No overflow is possible at ACC_W.
- TERMS=1: the first transfer goes straight to DONE.

Optional Feature:
- Macro: BOOTH_MAC_SAT_EN.
- When defined:
  - Adds output port sat (1 bit).
  - In DONE, acc_out is clamped to the signed 2*BITS range [-2^(2*BITS-1), 2^(2*BITS-1)-1], sign-extended to ACC_W.
  - sat=1 when clamping occurred; sat is valid with acc_valid and is 0 otherwise.
  - The internal sum stays full-width; only the presented value is clamped.
- When undefined: no sat port, and acc_out is the full-width sum.

Decomposition:
- Shared package booth_pkg holds:
  - FSM state enum (IDLE/ACCUM/DONE)
  - default BITS/TERMS constants
  - ACC_W computation function
- Natural sub-module: booth_mac_sat, a combinational clamp plus flag, instantiated only under BOOTH_MAC_SAT_EN.

Test Plan:
- BITS=8, TERMS=4: start; products 100, 200, -50, 16384 (p_valid continuous) -> acc_valid one cycle after the 4th transfer; acc_out=16634; term_cnt=4.
- Stall: same products with p_valid low for 3 cycles between terms, acc_ready held low 5 cycles in DONE -> acc_out stable at 16634 throughout DONE; returns to IDLE the cycle after acc_ready=1.
- Negative sum: four products of -16384 -> acc_out=-65536 (18-bit 0x30000), sign correct.
- Restart: 2 products of 500, then start with p_valid=1 and p_data=7 in the same cycle, then 4 products of 1 -> acc_out=4; the 7 is discarded.
- Reset mid-run: rst after 3 products -> the next cycle shows acc_out=0, acc_valid=0, p_ready=0, state IDLE; start in DONE is ignored.
- With BOOTH_MAC_SAT_EN: four products of 16384 -> acc_out=32767, sat=1; products 1, 2, 3, 4 -> acc_out=10, sat=0.
